// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus and extracts load data; MEM_MISALIGN_CHECK_EN adds a misaligned-load flag.
// Latency: 1 cycle from EX to the MEM->WB/forward buses; read data is used combinationally in the first MEM cycle, then held.
// Backpressure: stall[3] holds this stage, and stall[3] with stall[4] clear inserts a bubble; the stage itself never stalls.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [75:0] ex_to_mem_bus,
    input  logic [4:0]  ex_load_bus,
    input  logic [65:0] ex_hi_lo_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] mem_to_wb_bus,
    output logic [37:0] mem_to_rf_bus,
    output logic [65:0] mem_hi_lo_bus,
    output logic        mem_addr_err
);

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    logic [75:0] ex_mem_q;
    logic [4:0]  load_q;
    logic [65:0] hi_lo_q;
    logic        first_cycle;
    logic [31:0] hold_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q    <= '0;
            load_q      <= '0;
            hi_lo_q     <= '0;
            first_cycle <= 1'b0;
        end else if (stall[3] == STOP && stall[4] == NO_STOP) begin
            ex_mem_q    <= '0;
            load_q      <= '0;
            hi_lo_q     <= '0;
            first_cycle <= 1'b0;
        end else if (stall[3] == NO_STOP) begin
            ex_mem_q    <= ex_to_mem_bus;
            load_q      <= ex_load_bus;
            hi_lo_q     <= ex_hi_lo_bus;
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
        end
    end

    // SRAM data is only valid in the first MEM cycle; keep it for as long as MEM holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_rdata <= '0;
        end else if (first_cycle) begin
            hold_rdata <= data_sram_rdata;
        end
    end

    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw;
    logic [1:0]  addr;

    assign pc         = ex_mem_q[75:44];
    assign sel_rf_res = ex_mem_q[38];
    assign rf_we      = ex_mem_q[37];
    assign rf_waddr   = ex_mem_q[36:32];
    assign ex_result  = ex_mem_q[31:0];
    assign {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw} = load_q;
    assign addr       = ex_result[1:0];

    logic unused_bits;
    assign unused_bits = ^{stall[5], stall[2:0], ex_mem_q[43:39]};

    logic [31:0] eff_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign eff_rdata = first_cycle ? data_sram_rdata : hold_rdata;

    always_comb begin
        byte_sel  = '0;
        half_sel  = '0;
        load_data = eff_rdata;
        case (addr)
            2'd0:    byte_sel = eff_rdata[7:0];
            2'd1:    byte_sel = eff_rdata[15:8];
            2'd2:    byte_sel = eff_rdata[23:16];
            default: byte_sel = eff_rdata[31:24];
        endcase
        half_sel = addr[1] ? eff_rdata[31:16] : eff_rdata[15:0];
        if (inst_lb) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (inst_lbu) begin
            load_data = {24'b0, byte_sel};
        end else if (inst_lh) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (inst_lhu) begin
            load_data = {16'b0, half_sel};
        end else if (inst_lw) begin
            load_data = eff_rdata;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign mem_addr_err = ((inst_lh | inst_lhu) & addr[0]) | (inst_lw & (addr != 2'd0));
`else
    assign mem_addr_err = 1'b0;
`endif

    logic        wb_we;
    logic [31:0] rf_wdata;

    assign wb_we    = rf_we & ~mem_addr_err;
    assign rf_wdata = sel_rf_res ? load_data : ex_result;

    assign mem_to_wb_bus = {pc, wb_we, rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {wb_we, rf_waddr, rf_wdata};
    assign mem_hi_lo_bus = hi_lo_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver predicts each cycle's outputs, monitor compares on the falling edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [75:0] ex_to_mem_bus;
    logic [4:0]  ex_load_bus;
    logic [65:0] ex_hi_lo_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_rf_bus;
    logic [65:0] mem_hi_lo_bus;
    logic        mem_addr_err;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .ex_load_bus    (ex_load_bus),
        .ex_hi_lo_bus   (ex_hi_lo_bus),
        .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_bus  (mem_to_wb_bus),
        .mem_to_rf_bus  (mem_to_rf_bus),
        .mem_hi_lo_bus  (mem_hi_lo_bus),
        .mem_addr_err   (mem_addr_err)
    );

    // kind: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw
    typedef struct packed {
        logic [31:0] pc;
        logic        en;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic [2:0]  kind;
        logic [65:0] hilo;
    } instr_t;

    typedef struct packed {
        logic [69:0] wb;
        logic [37:0] rf;
        logic [65:0] hl;
        logic        err;
        logic        kchk;
        logic [31:0] kw;
        logic        kwe;
    } exp_t;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_CHK = 1'b1;
`else
    localparam bit MIS_CHK = 1'b0;
`endif

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    instr_t m;          // instruction currently in MEM
    bit     fresh;      // MEM instruction is in its first cycle
    logic [31:0] held;  // word seen in the first cycle, kept afterwards
    bit     cur_rst, cur_s3, cur_s4;
    instr_t cur_nx;
    logic [31:0] cur_rd;

    function automatic instr_t mk(input int kind, input logic [31:0] res, input logic [4:0] wa);
        instr_t t;
        t        = '0;
        t.pc     = 32'hBFC0_0000 + res;
        t.kind   = 3'(kind);
        t.sel    = (kind != 0);
        t.en     = (kind != 0);
        t.we     = 1'b1;
        t.waddr  = wa;
        t.result = res;
        return t;
    endfunction

    function automatic exp_t predict(input instr_t i, input bit fr, input logic [31:0] hd,
                                     input logic [31:0] rd);
        exp_t e;
        logic [31:0] word, ld, wd;
        logic [7:0]  b;
        logic [15:0] h;
        int          a;
        bit          mis, we;
        e    = '0;
        word = fr ? rd : hd;
        a    = int'(i.result[1:0]);
        b    = 8'((word >> (8 * a)) & 32'hFF);
        h    = 16'((word >> (16 * (a / 2))) & 32'hFFFF);
        case (i.kind)
            3'd1:    ld = 32'(signed'(b));
            3'd2:    ld = 32'(b);
            3'd3:    ld = 32'(signed'(h));
            3'd4:    ld = 32'(h);
            default: ld = word;
        endcase
        wd  = i.sel ? ld : i.result;
        mis = MIS_CHK && ((((i.kind == 3'd3) || (i.kind == 3'd4)) && (a % 2 == 1)) ||
                          ((i.kind == 3'd5) && (a != 0)));
        we  = i.we && !mis;
        e.wb  = {i.pc, we, i.waddr, wd};
        e.rf  = {we, i.waddr, wd};
        e.hl  = i.hilo;
        e.err = mis;
        return e;
    endfunction

    task automatic drive();
        rst             = cur_rst;
        stall           = {1'($urandom), cur_s4, cur_s3, 3'($urandom)};
        ex_to_mem_bus   = {cur_nx.pc, cur_nx.en, cur_nx.wen, cur_nx.sel, cur_nx.we,
                           cur_nx.waddr, cur_nx.result};
        ex_load_bus     = (cur_nx.kind == 3'd0) ? 5'd0 : 5'(5'd1 << (5 - int'(cur_nx.kind)));
        ex_hi_lo_bus    = cur_nx.hilo;
        data_sram_rdata = cur_rd;
    endtask

    // One cycle: advance model across the posedge, apply new inputs, predict outputs.
    task automatic step(input bit r, input bit s3, input bit s4, input instr_t nx,
                        input logic [31:0] rd, input bit kc, input logic [31:0] kw, input bit kwe);
        exp_t e;
        @(posedge clk);
        if (cur_rst) begin
            m = '0; fresh = 1'b0; held = '0;
        end else begin
            if (fresh) held = cur_rd;
            if (cur_s3 && !cur_s4) begin
                m = '0; fresh = 1'b0;
            end else if (!cur_s3) begin
                m = cur_nx; fresh = 1'b1;
            end else begin
                fresh = 1'b0;
            end
        end
        #1;
        cur_rst = r; cur_s3 = s3; cur_s4 = s4; cur_nx = nx; cur_rd = rd;
        drive();
        e      = predict(m, fresh, held, rd);
        e.kchk = kc;
        e.kw   = kw;
        e.kwe  = kwe;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_bus", 128'(mem_to_wb_bus), 128'(e.wb));
            chk("rf_bus", 128'(mem_to_rf_bus), 128'(e.rf));
            chk("hi_lo_bus", 128'(mem_hi_lo_bus), 128'(e.hl));
            chk("addr_err", 128'(mem_addr_err), 128'(e.err));
            if (e.kchk) begin
                chk("known_wdata", 128'(mem_to_wb_bus[31:0]), 128'(e.kw));
                chk("known_we", 128'(mem_to_wb_bus[37]), 128'(e.kwe));
            end
        end
    end

    initial begin
        instr_t nop, alu, t;
        int     ssel;
        bit     rr, s3, s4;
        nop = '0;
        cur_rst = 1'b1; cur_s3 = 1'b0; cur_s4 = 1'b0; cur_nx = nop; cur_rd = '0;
        m = '0; fresh = 1'b0; held = '0;
        drive();

        step(1, 0, 0, nop, 32'h0, 1, 32'h0, 0);
        step(1, 0, 0, nop, 32'h0, 1, 32'h0, 0);
        alu = mk(0, 32'h1234, 5'd5);
        step(0, 0, 0, alu, 32'h0, 1, 32'h0, 0);
        step(0, 0, 0, mk(1, 32'h0000_0103, 5'd1), 32'h0, 1, 32'h1234, 1);
        step(0, 0, 0, mk(2, 32'h0000_0203, 5'd2), 32'h80FF_7F01, 1, 32'hFFFF_FF80, 1);
        step(0, 0, 0, mk(1, 32'h0000_0300, 5'd3), 32'h80FF_7F01, 1, 32'h0000_0080, 1);
        step(0, 0, 0, mk(3, 32'h0000_0402, 5'd4), 32'h80FF_7F01, 1, 32'h0000_0001, 1);
        step(0, 0, 0, mk(4, 32'h0000_0500, 5'd6), 32'h8001_ABCD, 1, 32'hFFFF_8001, 1);
        step(0, 0, 0, mk(5, 32'h0000_0600, 5'd7), 32'h8001_ABCD, 1, 32'h0000_ABCD, 1);
        step(0, 0, 0, mk(5, 32'h0000_0100, 5'd8), 32'h8001_ABCD, 1, 32'h8001_ABCD, 1);
        step(0, 1, 1, alu, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1);
        repeat (4) step(0, 1, 1, alu, 32'h0, 1, 32'hDEAD_BEEF, 1);
        t = mk(0, 32'h55, 5'd9);
        t.hilo = {1'b1, 1'b1, 32'h1, 32'h2};
        step(0, 0, 0, t, 32'h0, 1, 32'hDEAD_BEEF, 1);
        step(0, 1, 0, alu, 32'h0, 1, 32'h55, 1);
        step(0, 0, 0, mk(5, 32'h0000_1002, 5'd10), 32'h0, 1, 32'h0, 0);
        step(0, 0, 0, nop, 32'h1122_3344, 1, 32'h1122_3344, !MIS_CHK);

        for (int n = 0; n < 400; n++) begin
            t        = mk(int'($urandom_range(0, 5)), $urandom, 5'($urandom));
            t.pc     = $urandom;
            t.we     = 1'($urandom);
            t.sel    = (t.kind != 0) ? 1'b1 : 1'($urandom);
            t.wen    = 4'($urandom);
            t.hilo   = {2'($urandom), $urandom, $urandom};
            ssel     = int'($urandom_range(0, 7));
            s3       = (ssel == 5) || (ssel == 6);
            s4       = (ssel == 6) || (ssel == 7);
            rr       = ($urandom_range(0, 39) == 0);
            step(rr, s3, s4, t, $urandom, 0, 32'h0, 0);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
